// File: rtl/io_mmio.sv
// Memory-mapped IO unit: UART status/RX/TX, cycle and instruction counters, registered read port.
// Define MMIO_RX_FIFO_EN for an RX_DEPTH-entry circular RX FIFO; otherwise a single holding register.
module io_mmio #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    output logic [31:0] io_dout
);

    if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_rx_depth
        $error("io_mmio: RX_DEPTH must be a power of two and at least 2");
    end

    logic        io_hit;
    logic [7:0]  offset;
    logic        io_read;
    logic        io_write;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        rx_push;
    logic        rx_pop;
    logic        tx_write;
    logic        cnt_clear;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] rd_word;

    // Only the low byte of the address and of the store data are meaningful here.
    logic unused_bits;
    assign unused_bits = ^{addr[27:8], wdata[31:8]};

    assign io_hit    = (addr[31:28] == 4'h8);
    assign offset    = addr[7:0];
    assign io_read   = ren && io_hit;
    assign io_write  = wen && io_hit;

    assign uart_rx_ready = !rx_full;
    assign rx_push   = uart_rx_valid && !rx_full;
    assign rx_pop    = io_read && (offset == 8'h04) && !rx_empty;
    assign tx_write  = io_write && (offset == 8'h08);
    assign cnt_clear = io_write && (offset == 8'h18);

`ifdef MMIO_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_DEPTH);

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   rx_count;

    assign rx_full  = (rx_count == (PTR_W + 1)'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_head  = rx_mem[rd_ptr];

    // Storage array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_hold_valid;

    assign rx_full  = rx_hold_valid;
    assign rx_empty = !rx_hold_valid;
    assign rx_head  = rx_hold;

    // A push needs an empty holder and a pop needs a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold       <= '0;
            rx_hold_valid <= 1'b0;
        end else if (rx_push) begin
            rx_hold       <= uart_rx_data;
            rx_hold_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_hold_valid <= 1'b0;
        end
    end
`endif

    // A store while the previous byte is still pending is dropped, even on the handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx_data  <= '0;
            uart_tx_valid <= 1'b0;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end else if (tx_write) begin
            uart_tx_data  <= wdata[7:0];
            uart_tx_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (cnt_clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            instr_cnt <= instr_cnt + {31'b0, inst_retire};
        end
    end

    always_comb begin
        rd_word = '0;
        case (offset)
            8'h00:   rd_word = {30'b0, !rx_empty, !uart_tx_valid};
            8'h04:   rd_word = rx_empty ? 32'd0 : {24'b0, rx_head};
            8'h10:   rd_word = cycle_cnt;
            8'h14:   rd_word = instr_cnt;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_dout <= '0;
        end else begin
            io_dout <= io_read ? rd_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_io_mmio.sv
// Directed self-checking bench for io_mmio; works with or without MMIO_RX_FIFO_EN.
module tb_io_mmio;

    localparam int RX_DEPTH = 4;
`ifdef MMIO_RX_FIFO_EN
    localparam int DEPTH = RX_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_UNMAP  = 32'h8000_000C;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_INSTR  = 32'h8000_0014;
    localparam logic [31:0] A_CLEAR  = 32'h8000_0018;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic        inst_retire;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [31:0] io_dout;

    int checks = 0;
    int errors = 0;

    io_mmio #(.RX_DEPTH(RX_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .ren           (ren),
        .wen           (wen),
        .inst_retire   (inst_retire),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .io_dout       (io_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Called on a falling edge; drives one MEM-stage cycle and returns on the next falling edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren   = r;
        wen   = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        ren   = 1'b0;
        wen   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        addr          = 32'h0;
        wdata         = 32'h0;
        ren           = 1'b0;
        wen           = 1'b0;
        inst_retire   = 1'b0;
        uart_rx_data  = 8'h0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset io_dout", io_dout, 32'h0);
        checkOutput("reset tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        checkOutput("reset tx_data", {24'b0, uart_tx_data}, 32'h0);
        rst = 1'b0;
        checkOutput("reset rx_ready", {31'b0, uart_rx_ready}, 32'h1);

        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        checkOutput("status after reset", io_dout, 32'h1);
        applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        checkOutput("dout after idle", io_dout, 32'h0);

        // Interleaved so the sequence also fits a single holding register.
        pushByte(8'h41);
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("rx read 0x41", io_dout, 32'h41);
        pushByte(8'h42);
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("rx read 0x42", io_dout, 32'h42);
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("rx read empty", io_dout, 32'h0);
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        checkOutput("status rx empty", io_dout, 32'h1);

        pushByte(8'h5A);
        applyStimulus(1'b1, 1'b0, 32'h1000_0004, 32'h0);
        checkOutput("non-io read", io_dout, 32'h0);
        applyStimulus(1'b1, 1'b0, A_UNMAP, 32'h0);
        checkOutput("unmapped read", io_dout, 32'h0);
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        checkOutput("status rx nonempty", io_dout, 32'h3);
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("rx read 0x5A", io_dout, 32'h5A);

        // Fill, offer one extra byte while full, then drain in order across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("rx_ready before fill push", {31'b0, uart_rx_ready}, 32'h1);
            pushByte(8'hA0 + 8'(i));
        end
        checkOutput("rx_ready when full", {31'b0, uart_rx_ready}, 32'h0);
        uart_rx_data  = 8'hE0;
        uart_rx_valid = 1'b1;
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("drain first byte", io_dout, 32'hA0);
        checkOutput("rx_ready after pop", {31'b0, uart_rx_ready}, 32'h1);
        @(negedge clk);
        uart_rx_valid = 1'b0;
        checkOutput("rx_ready refilled", {31'b0, uart_rx_ready}, 32'h0);
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
            checkOutput("drain in order", io_dout, 32'hA0 + i);
        end
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("drain held-off byte", io_dout, 32'hE0);
        applyStimulus(1'b1, 1'b0, A_RXDATA, 32'h0);
        checkOutput("drain empty", io_dout, 32'h0);

        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h155);
        checkOutput("tx_valid after store", {31'b0, uart_tx_valid}, 32'h1);
        checkOutput("tx_data after store", {24'b0, uart_tx_data}, 32'h55);
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        checkOutput("status tx busy", io_dout, 32'h0);
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h66);
        checkOutput("tx store while busy", {24'b0, uart_tx_data}, 32'h55);
        uart_tx_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h77);
        uart_tx_ready = 1'b0;
        checkOutput("tx_valid after handshake", {31'b0, uart_tx_valid}, 32'h0);
        checkOutput("tx store on handshake", {24'b0, uart_tx_data}, 32'h55);
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h12);
        checkOutput("tx_data second store", {24'b0, uart_tx_data}, 32'h12);
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        checkOutput("tx_valid one-cycle ready", {31'b0, uart_tx_valid}, 32'h0);
        checkOutput("tx_data held", {24'b0, uart_tx_data}, 32'h12);

        for (int i = 0; i < 10; i++) begin
            inst_retire = (i == 2) || (i == 5) || (i == 7);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        applyStimulus(1'b1, 1'b0, A_INSTR, 32'h0);
        checkOutput("instr count", io_dout, 32'h3);
        // One cycle elapses between the clear and the read, so the cycle counter reads 1.
        applyStimulus(1'b0, 1'b1, A_CLEAR, 32'hDEAD);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle after clear", io_dout, 32'h1);
        applyStimulus(1'b1, 1'b0, A_INSTR, 32'h0);
        checkOutput("instr after clear", io_dout, 32'h0);

        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle wrap", io_dout, 32'h0);

        pushByte(8'h77);
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h33);
        checkOutput("tx pending before reset", {31'b0, uart_tx_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        checkOutput("async reset rx_ready", {31'b0, uart_rx_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        checkOutput("status after mid reset", io_dout, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_mmio.md
# io_mmio

Memory-mapped I/O unit for the RISC-V core: decodes MEM-stage loads/stores in the IO region (addr[31:28] = 4'h8), owns the UART byte handshakes, an RX byte FIFO, and the cycle/instruction counters. It produces a registered read word, `io_dout`, that arrives in the following cycle. The writeback stage consumes it as its IO data-out input, with the same one-cycle sync-read timing as BIOS and DMEM.

## Interface
- `RX_DEPTH`, 4: RX FIFO entries. Must be a power of two, ≥2. Only used when the macro is defined.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `addr` input 32: MEM-stage ALU address.
- `wdata` input 32: MEM-stage store data (rs2, unshifted).
- `ren` input 1: load in MEM stage, already qualified by valid/stall upstream.
- `wen` input 1: store in MEM stage, already qualified.
- `inst_retire` input 1: one pulse per retired instruction.
- `uart_rx_data` input 8: received byte.
- `uart_rx_valid` input 1: receiver offers a byte.
- `uart_rx_ready` output 1: FIFO accepts a byte; combinational `!full`.
- `uart_tx_data` output 8: byte to transmit.
- `uart_tx_valid` output 1: transmit request pending.
- `uart_tx_ready` input 1: transmitter accepts the byte.
- `io_dout` output 32: registered read data, aligned with the WB stage.

## Operation
- A cycle hits the IO region when addr[31:28] = 4'h8. Only addr[7:0] is decoded. Unmapped offsets read 0 and ignore writes.
- Offset 0x00, read-only: {30'b0, rx_nonempty, tx_ready}, where `tx_ready` = `!uart_tx_valid`.
- Offset 0x04, read:
  - FIFO non-empty: returns {24'b0, head} and pops the head.
  - FIFO empty: returns 0, no pop.
- Offset 0x08, write:
  - `uart_tx_valid` = 0: loads wdata[7:0] into `uart_tx_data` and sets `uart_tx_valid`.
  - `uart_tx_valid` = 1: the write is dropped.
- Offset 0x10, read: cycle counter. Increments every cycle after reset.
- Offset 0x14, read: instruction counter. Increments on `inst_retire`.
- Offset 0x18, write (any data): both counters are 0 after the edge. The increment that edge is suppressed.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0 silently.
- RX push: occurs when `uart_rx_valid` && `uart_rx_ready`. FIFO ordering is strict FIFO.
- TX handshake: `uart_tx_valid` clears on the edge where `uart_tx_valid` && `uart_tx_ready`. `uart_tx_data` holds its value until the next accepted write.
- A write to 0x08 in the same cycle as the handshake completes is dropped, because status was busy.
- Simultaneous `ren` and `wen` is illegal; the bench never drives it.

## Timing
- Read latency is 1 cycle. `io_dout` is registered on the edge after `ren`. It is 0 on any cycle following a non-IO or non-read cycle.
- Pop and counter snapshot take effect at the same edge that registers `io_dout`.
- Push and pop in the same cycle on a non-empty, non-full FIFO: count is unchanged, and the head advances.
- Push and pop in the same cycle on an empty FIFO: the pop returns 0, and the pushed byte is stored.
- Push when full is never accepted, because `uart_rx_ready` = 0. This holds even if a pop happens that same cycle; the pop frees a slot for the next cycle.
- Reset values: `io_dout` = 0, `uart_tx_valid` = 0, `uart_tx_data` = 0, counters = 0, FIFO empty. Therefore `uart_rx_ready` = 1 once reset deasserts.
- Reset asserted mid-operation discards the FIFO contents and any pending TX byte immediately; there is no partial handshake.

## Configuration
- `MMIO_RX_FIFO_EN` defined: the RX buffer is a circular FIFO of `RX_DEPTH` entries with wrap-around pointers and an occupancy count of log2(RX_DEPTH)+1 bits.
- `MMIO_RX_FIFO_EN` undefined: the RX buffer is a single holding register with a valid bit, and `RX_DEPTH` is ignored. All status, pop and push rules above still apply, with full = valid.

## Test plan
- Reset, then read 0x80000000: `io_dout` = 0x00000001 one cycle later, and `uart_rx_ready` = 1.
- Push bytes 0x41, 0x42, then read 0x80000004 twice: responses are 0x41, then 0x42. A third read returns 0, and status bit1 = 0.
- Push RX_DEPTH+1 bytes with no reads (macro on):
  - `uart_rx_ready` drops after RX_DEPTH pushes.
  - The extra byte is held off by the source.
  - Reads return all bytes in order and exercise pointer wrap.
- Store 0x155 to 0x80000008 with `uart_tx_ready` = 0:
  - `uart_tx_valid` = 1 and `uart_tx_data` = 0x55.
  - A second store of 0x66 is dropped.
  - Raising `uart_tx_ready` for one cycle clears `uart_tx_valid`.
- Run 10 cycles with 3 `inst_retire` pulses, then store to 0x80000018, then read 0x10 and 0x14 back to back:
  - The 0x10 read returns 1 (the counter counted the one cycle after the clear).
  - The 0x14 read returns 0, with no retires after the clear.
- Force the cycle counter to 0xFFFFFFFF (via a force in the bench), then advance one cycle: a read of 0x10 returns 0x00000000 (wrap). Assert `rst` while the FIFO is non-empty: status reads 0x1 afterwards.
